// File: rtl/game_pkg.sv
// Shared types and constants for the brick-breaker play controller.
package game_pkg;

    localparam int SCORE_W   = 10;
    localparam int SCORE_MAX = 999;
    localparam int LIVES_W   = 2;
    localparam int STATE_W   = 3;
    localparam int WAIT_W    = 16;

    localparam int DEF_NUM_BRICKS      = 6;
    localparam int DEF_TICK_DIV        = 833333;
    localparam int DEF_LIVES_INIT      = 3;
    localparam int DEF_LOST_TICKS      = 60;
    localparam int DEF_CLEAR_TICKS     = 120;
    localparam int SERVE_TIMEOUT_TICKS = 180;

    typedef enum logic [STATE_W-1:0] {
        ST_ATTRACT = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_LOST    = 3'd3,
        ST_CLEARED = 3'd4,
        ST_OVER    = 3'd5
    } state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Event inputs and control/status outputs between the sequencer (master) and the datapath (slave).
interface game_sequencer_if #(
    parameter int NUM_BRICKS = game_pkg::DEF_NUM_BRICKS
);
    import game_pkg::*;

    logic                  launch_btn;
    logic                  ball_lost;
    logic [NUM_BRICKS-1:0] brick_hit;
    logic [NUM_BRICKS-1:0] brick_exist;

    logic                  frame_tick;
    logic                  ball_step;
    logic                  brick_step;
    logic                  ball_hold;
    logic                  ball_start;
    logic                  brick_respawn;
    logic [LIVES_W-1:0]    lives;
    logic [SCORE_W-1:0]    score;
    logic [STATE_W-1:0]    state;
    logic                  game_over;

    modport master (
        input  launch_btn, ball_lost, brick_hit, brick_exist,
        output frame_tick, ball_step, brick_step, ball_hold, ball_start,
               brick_respawn, lives, score, state, game_over
    );

    modport slave (
        output launch_btn, ball_lost, brick_hit, brick_exist,
        input  frame_tick, ball_step, brick_step, ball_hold, ball_start,
               brick_respawn, lives, score, state, game_over
    );

endinterface

// File: rtl/game_sequencer_frame_tick.sv
// Free-running divider: frame_tick_o is high for one cycle every TICK_DIV cycles (TICK_DIV >= 2).
module frame_tick_gen #(
    parameter int TICK_DIV = game_pkg::DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick_o
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Tick is registered one count early so it lines up with the terminal count.
    always_comb begin
        cnt_d  = (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_q == CW'(TICK_DIV - 2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick_o = tick_q;

endmodule

// File: rtl/game_sequencer.sv
// Play controller: game FSM, frame tick, lives/score bookkeeping and datapath step/launch strobes.
// Optional macro SERVE_TIMEOUT_EN: SERVE auto-launches after SERVE_TIMEOUT_TICKS frame ticks.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int NUM_BRICKS  = DEF_NUM_BRICKS,
    parameter int LIVES_INIT  = DEF_LIVES_INIT,
    parameter int LOST_TICKS  = DEF_LOST_TICKS,
    parameter int CLEAR_TICKS = DEF_CLEAR_TICKS
) (
    input logic              clk,
    input logic              rst,
    game_sequencer_if.master bus
);
    logic frame_tick;

    frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_frame_tick (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_o (frame_tick)
    );

    state_t                state_q, state_d;
    logic [LIVES_W-1:0]    lives_q, lives_d;
    logic [SCORE_W-1:0]    score_q, score_d, score_sat;
    logic [SCORE_W:0]      score_sum;
    logic [WAIT_W-1:0]     wait_q, wait_d, wait_inc;
    logic                  btn_q, press;
    logic                  ball_start_q, ball_start_d;
    logic                  respawn_q, respawn_d;
    logic                  ball_step_q, brick_step_q, ball_hold_q, game_over_q;
    logic [NUM_BRICKS-1:0] bricks_left;

    assign press       = bus.launch_btn & ~btn_q;
    assign bricks_left = bus.brick_exist & ~bus.brick_hit;
    assign score_sum   = {1'b0, score_q} + (SCORE_W+1)'($countones(bus.brick_hit));
    assign score_sat   = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                               : score_sum[SCORE_W-1:0];
    assign wait_inc    = wait_q + WAIT_W'(frame_tick);

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        score_d      = score_q;
        wait_d       = wait_q;
        ball_start_d = 1'b0;
        respawn_d    = 1'b0;
        case (state_q)
            ST_ATTRACT: begin
                if (press) begin
                    state_d   = ST_SERVE;
                    lives_d   = LIVES_W'(LIVES_INIT);
                    score_d   = '0;
                    respawn_d = 1'b1;
                    wait_d    = '0;
                end
            end
            ST_SERVE: begin
                if (press) begin
                    state_d      = ST_PLAY;
                    ball_start_d = 1'b1;
                end
`ifdef SERVE_TIMEOUT_EN
                else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_W'(SERVE_TIMEOUT_TICKS)) begin
                        state_d      = ST_PLAY;
                        ball_start_d = 1'b1;
                    end
                end
`endif
            end
            ST_PLAY: begin
                // Hits are scored even in the cycle that clears the wall or loses the ball.
                score_d = score_sat;
                if (bricks_left == '0) begin
                    state_d = ST_CLEARED;
                    wait_d  = '0;
                end else if (bus.ball_lost) begin
                    state_d = ST_LOST;
                    lives_d = lives_q - LIVES_W'(1);
                    wait_d  = '0;
                end
            end
            ST_LOST: begin
                if (lives_q == '0) begin
                    state_d = ST_OVER;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_W'(LOST_TICKS)) begin
                        state_d = ST_SERVE;
                        wait_d  = '0;
                    end
                end
            end
            ST_CLEARED: begin
                wait_d = wait_inc;
                if (wait_inc == WAIT_W'(CLEAR_TICKS)) begin
                    state_d   = ST_SERVE;
                    respawn_d = 1'b1;
                    wait_d    = '0;
                end
            end
            ST_OVER: begin
                if (press) state_d = ST_ATTRACT;
            end
            default: state_d = ST_ATTRACT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ATTRACT;
            lives_q      <= LIVES_W'(LIVES_INIT);
            score_q      <= '0;
            wait_q       <= '0;
            btn_q        <= 1'b0;
            ball_start_q <= 1'b0;
            respawn_q    <= 1'b0;
            ball_step_q  <= 1'b0;
            brick_step_q <= 1'b0;
            ball_hold_q  <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            wait_q       <= wait_d;
            btn_q        <= bus.launch_btn;
            ball_start_q <= ball_start_d;
            respawn_q    <= respawn_d;
            ball_step_q  <= frame_tick & (state_q == ST_PLAY);
            brick_step_q <= frame_tick & ((state_q == ST_PLAY) | (state_q == ST_CLEARED));
            ball_hold_q  <= (state_d != ST_PLAY);
            game_over_q  <= (state_d == ST_OVER);
        end
    end

    assign bus.frame_tick    = frame_tick;
    assign bus.ball_step     = ball_step_q;
    assign bus.brick_step    = brick_step_q;
    assign bus.ball_hold     = ball_hold_q;
    assign bus.ball_start    = ball_start_q;
    assign bus.brick_respawn = respawn_q;
    assign bus.lives         = lives_q;
    assign bus.score         = score_q;
    assign bus.state         = state_q;
    assign bus.game_over     = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random play, checked every cycle against a game-rule model.
module tb_game_sequencer;
    localparam int TD = 4;
    localparam int NB = 6;
    localparam int LI = 3;
    localparam int LT = 2;
    localparam int CT = 3;
    localparam int A = 0, S = 1, P = 2, L = 3, C = 4, O = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          launch_btn = 1'b0;
    logic          ball_lost  = 1'b0;
    logic [NB-1:0] brick_hit   = '0;
    logic [NB-1:0] brick_exist = '1;

    int n_checks = 0;
    int n_fail   = 0;

    game_sequencer_if #(.NUM_BRICKS(NB)) bus ();

    assign bus.launch_btn  = launch_btn;
    assign bus.ball_lost   = ball_lost;
    assign bus.brick_hit   = brick_hit;
    assign bus.brick_exist = brick_exist;

    game_sequencer #(
        .TICK_DIV(TD), .NUM_BRICKS(NB), .LIVES_INIT(LI),
        .LOST_TICKS(LT), .CLEAR_TICKS(CT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Game-rule model: cycles since reset, state by number, lives, score and ticks spent in the current state.
    int m_cyc, m_st, m_lives, m_score, m_seen;
    bit m_btn, m_bstart, m_resp, m_bstep, m_kstep;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_st = A; m_lives = LI; m_score = 0; m_seen = 0;
            m_btn = 0; m_bstart = 0; m_resp = 0; m_bstep = 0; m_kstep = 0;
        end else begin : model_step
            bit tick, press;
            int nst;
            tick    = (m_cyc % TD) == TD - 1;
            press   = launch_btn && !m_btn;
            m_btn   = launch_btn;
            m_cyc++;
            m_bstep = tick && (m_st == P);
            m_kstep = tick && (m_st == P || m_st == C);
            m_bstart = 0;
            m_resp   = 0;
            nst      = m_st;
            case (m_st)
                A: if (press) begin nst = S; m_lives = LI; m_score = 0; m_resp = 1; end
                S: begin
                    if (press) begin nst = P; m_bstart = 1; end
`ifdef SERVE_TIMEOUT_EN
                    else begin
                        m_seen += int'(tick);
                        if (m_seen == 180) begin nst = P; m_bstart = 1; end
                    end
`endif
                end
                P: begin
                    m_score += $countones(brick_hit);
                    if (m_score > 999) m_score = 999;
                    if ((brick_exist & ~brick_hit) == '0) nst = C;
                    else if (ball_lost) begin nst = L; m_lives--; end
                end
                L: begin
                    if (m_lives == 0) nst = O;
                    else begin
                        m_seen += int'(tick);
                        if (m_seen == LT) nst = S;
                    end
                end
                C: begin
                    m_seen += int'(tick);
                    if (m_seen == CT) begin nst = S; m_resp = 1; end
                end
                O: if (press) nst = A;
                default: nst = A;
            endcase
            if (nst != m_st) m_seen = 0;
            m_st = nst;
        end
    end

    always @(negedge clk) begin
        chk("frame_tick",    bus.frame_tick,    32'((m_cyc % TD) == TD - 1));
        chk("ball_step",     bus.ball_step,     32'(m_bstep));
        chk("brick_step",    bus.brick_step,    32'(m_kstep));
        chk("ball_hold",     bus.ball_hold,     32'(m_st != P));
        chk("ball_start",    bus.ball_start,    32'(m_bstart));
        chk("brick_respawn", bus.brick_respawn, 32'(m_resp));
        chk("lives",         bus.lives,         m_lives);
        chk("score",         bus.score,         m_score);
        chk("state",         bus.state,         m_st);
        chk("game_over",     bus.game_over,     32'(m_st == O));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press1();
        launch_btn = 1'b1; cyc(1);
        launch_btn = 1'b0; cyc(1);
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int n = 0;
        while (bus.state !== 3'(s) && n < budget) begin cyc(1); n++; end
        chk(nm, bus.state, s);
    endtask

    task automatic reset_values(input string nm);
        chk({nm, "_state"}, bus.state, A);
        chk({nm, "_lives"}, bus.lives, LI);
        chk({nm, "_score"}, bus.score, 0);
        chk({nm, "_game_over"}, bus.game_over, 0);
        chk({nm, "_ball_hold"}, bus.ball_hold, 1);
        chk({nm, "_strobes"}, {bus.frame_tick, bus.ball_step, bus.brick_step,
                               bus.ball_start, bus.brick_respawn}, 0);
    endtask

    initial begin
        int cnt;
        cyc(2);
        reset_values("reset");
        rst = 1'b0;

        // Tick period after reset: counter value k is visible in cycle k+1.
        chk("tick_c1", bus.frame_tick, 0);
        for (int c = 2; c <= 12; c++) begin
            cyc(1);
            chk("tick_period", bus.frame_tick, 32'((c % 4) == 0));
            chk("attract_steps", {bus.ball_step, bus.brick_step}, 0);
        end

        // Start game and launch with a held button.
        launch_btn = 1'b1; cyc(1);
        chk("start_state", bus.state, 1);
        chk("start_lives", bus.lives, 3);
        chk("start_respawn", bus.brick_respawn, 1);
        cyc(3);
        chk("held_no_respawn", bus.brick_respawn, 0);
        chk("held_still_serve", bus.state, 1);
        launch_btn = 1'b0; cyc(1);
        launch_btn = 1'b1; cyc(1);
        chk("launch_state", bus.state, 2);
        chk("launch_start", bus.ball_start, 1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin cyc(1); cnt += int'(bus.ball_start); end
        chk("held_single_start", cnt, 0);
        launch_btn = 1'b0;
        cnt = 0;
        while (bus.frame_tick !== 1'b1 && cnt < 8) begin cyc(1); cnt++; end
        chk("tick_seen_in_play", bus.frame_tick, 1);
        cyc(1);
        chk("ball_step_follows", bus.ball_step, 1);

        // Scoring and saturation.
        brick_hit = 6'b000101; cyc(1); brick_hit = '0;
        chk("score_plus2", bus.score, 2);
        for (int i = 0; i < 199; i++) begin brick_hit = 6'b011111; cyc(1); end
        brick_hit = 6'b000001; cyc(1);
        chk("score_998", bus.score, 998);
        brick_hit = 6'b000011; cyc(1);
        chk("score_sat_999", bus.score, 999);
        brick_hit = 6'b000001; cyc(1);
        chk("score_stays_999", bus.score, 999);
        brick_hit = '0;

        // Three lost balls end the game.
        for (int k = 1; k <= 3; k++) begin
            ball_lost = 1'b1; cyc(1); ball_lost = 1'b0;
            chk("lost_state", bus.state, 3);
            chk("lost_lives", bus.lives, 3 - k);
            if (k < 3) begin
                wait_state(S, 40, "reserve");
                press1();
                chk("relaunch", bus.state, 2);
            end
        end
        cyc(1);
        chk("over_state", bus.state, 5);
        chk("over_flag", bus.game_over, 1);
        launch_btn = 1'b1; cyc(1); launch_btn = 1'b0;
        chk("over_to_attract", bus.state, 0);
        cyc(1);

        // Clear and loss in the same cycle: clear wins, hit still scores.
        press1(); press1();
        chk("play_again", bus.state, 2);
        brick_exist = 6'b000001; brick_hit = 6'b000001; ball_lost = 1'b1;
        cyc(1);
        brick_exist = '1; brick_hit = '0; ball_lost = 1'b0;
        chk("clear_state", bus.state, 4);
        chk("clear_lives", bus.lives, 3);
        chk("clear_score", bus.score, 1);
        cnt = 0;
        while (bus.brick_respawn !== 1'b1 && cnt < 40) begin cyc(1); cnt++; end
        chk("clear_respawn", bus.brick_respawn, 1);
        chk("clear_to_serve", bus.state, 1);

        // Asynchronous reset in the middle of PLAY.
        press1();
        chk("play_before_rst", bus.state, 2);
        cyc(3);
        #2 rst = 1'b1;
        #1 reset_values("async_rst");
        cyc(1);
        rst = 1'b0;

        // Random play against the model.
        for (int i = 0; i < 4000; i++) begin
            launch_btn  = ($urandom_range(0, 3) == 0);
            ball_lost   = ($urandom_range(0, 19) == 0);
            brick_exist = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom);
            brick_hit   = ($urandom_range(0, 2) == 0) ? NB'($urandom) & brick_exist : '0;
            cyc(1);
        end
        launch_btn = 1'b0; ball_lost = 1'b0; brick_hit = '0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
